// File: rtl/rn_wr_tgt_tracker.sv
// RN-side AXI3 write tracker: steers W beats to the target node recorded on the matching AW.
// Optional WLAST/beat-count checker enabled by defining RN_WR_TRK_ERR_CHK_EN.
module rn_wr_tgt_tracker #(
   parameter int unsigned TRK_NUM = 16,
   parameter int unsigned ID_W    = 11,
   parameter int unsigned TGT_W   = 2,
   parameter int unsigned LEN_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         AWVALID,
   input  logic                         AWREADY,
   input  logic [ID_W-1:0]              AWID,
   input  logic [LEN_W-1:0]             AWLEN,
   input  logic [TGT_W-1:0]             AW_TgtID,
   output logic                         trk_full,
   output logic [$clog2(TRK_NUM):0]     trk_cnt,
   input  logic                         WVALID,
   input  logic                         WREADY,
   input  logic [ID_W-1:0]              WID,
   input  logic                         WLAST,
   output logic [TGT_W-1:0]             W_TgtID,
   output logic                         w_hit,
   output logic                         err_wlast
);

   localparam int unsigned IDX_W = $clog2(TRK_NUM);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned BL_W  = LEN_W + 1;

   logic [TRK_NUM-1:0] valid_q;
   logic [ID_W-1:0]    id_q    [TRK_NUM];
   logic [TGT_W-1:0]   tgt_q   [TRK_NUM];
   logic [BL_W-1:0]    bl_q    [TRK_NUM];
   logic [TRK_NUM-1:0] older_q [TRK_NUM];   // older_q[i][j]: entry i is older than entry j
   logic [CNT_W-1:0]   cnt_q;
   logic               full_q;

   logic [TRK_NUM-1:0] cand;
   logic               hit_st;
   logic               oldest;
   logic [IDX_W-1:0]   own_idx;
   logic [IDX_W-1:0]   alloc_idx;
   logic               aw_hs;
   logic               byp;
   logic               w_beat;
   logic               st_beat;
   logic               byp_beat;
   logic               dealloc;
   logic               alloc;
   logic [BL_W-1:0]    alloc_bl;
   logic [CNT_W-1:0]   cnt_nxt;

   always_comb begin
      cand = '0;
      for (int i = 0; i < int'(TRK_NUM); i++) begin
         cand[i] = valid_q[i] && (id_q[i] == WID);
      end
   end

   // Owner is the candidate older than every other candidate with the same ID.
   always_comb begin
      hit_st  = 1'b0;
      own_idx = '0;
      oldest  = 1'b0;
      for (int i = 0; i < int'(TRK_NUM); i++) begin
         if (cand[i]) begin
            oldest = 1'b1;
            for (int j = 0; j < int'(TRK_NUM); j++) begin
               if (j != i && cand[j] && !older_q[i][j]) oldest = 1'b0;
            end
            if (oldest) begin
               hit_st  = 1'b1;
               own_idx = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      alloc_idx = '0;
      for (int i = int'(TRK_NUM) - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_idx = IDX_W'(i);
      end
   end

   assign aw_hs    = AWVALID && AWREADY && !full_q;
   assign byp      = !hit_st && aw_hs && (AWID == WID);
   assign w_hit    = hit_st || byp;
   assign W_TgtID  = hit_st ? tgt_q[own_idx] : (byp ? AW_TgtID : '0);
   assign w_beat   = WVALID && WREADY && w_hit;
   assign st_beat  = w_beat && hit_st;
   assign byp_beat = w_beat && byp;
   assign dealloc  = st_beat && (bl_q[own_idx] == BL_W'(1));
   // A bypassed single-beat burst completes in the AW cycle and never occupies an entry.
   assign alloc    = aw_hs && !(byp_beat && (AWLEN == '0));
   assign alloc_bl = byp_beat ? BL_W'(AWLEN) : BL_W'(AWLEN) + BL_W'(1);
   assign cnt_nxt  = cnt_q + CNT_W'(alloc) - CNT_W'(dealloc);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         for (int i = 0; i < int'(TRK_NUM); i++) begin
            id_q[i]    <= '0;
            tgt_q[i]   <= '0;
            bl_q[i]    <= '0;
            older_q[i] <= '0;
         end
      end else begin
         if (st_beat) begin
            bl_q[own_idx] <= bl_q[own_idx] - BL_W'(1);
            if (dealloc) valid_q[own_idx] <= 1'b0;
         end
         if (alloc) begin
            valid_q[alloc_idx] <= 1'b1;
            id_q[alloc_idx]    <= AWID;
            tgt_q[alloc_idx]   <= AW_TgtID;
            bl_q[alloc_idx]    <= alloc_bl;
            for (int j = 0; j < int'(TRK_NUM); j++) begin
               older_q[j][alloc_idx] <= valid_q[j];
            end
            older_q[alloc_idx] <= '0;
         end
         cnt_q  <= cnt_nxt;
         full_q <= (cnt_nxt == CNT_W'(TRK_NUM));
      end
   end

   assign trk_cnt  = cnt_q;
   assign trk_full = full_q;

`ifdef RN_WR_TRK_ERR_CHK_EN
   logic err_q;
   logic exp_last;

   assign exp_last = hit_st ? (bl_q[own_idx] == BL_W'(1)) : (AWLEN == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (w_beat && (WLAST != exp_last)) begin
         err_q <= 1'b1;
      end
   end

   assign err_wlast = err_q;
`else
   logic unused_wlast;

   assign unused_wlast = WLAST;
   assign err_wlast    = 1'b0;
`endif

endmodule
